// File: rtl/ppm_pkg.sv
// ppm_pkg: shared FSM state encoding and constants for pulse_period_monitor
package ppm_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;
  localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/ppm_edge_det.sv
// ppm_edge_det: rising-edge detector; define PULSE_SYNC_EN to put a 2-flop synchronizer in front
module ppm_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic rise
);
  logic src;
  logic pulse_d;
`ifdef PULSE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], pulse_in};
  assign src = sync[1];
`else
  assign src = pulse_in;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pulse_d <= 1'b0;
    else pulse_d <= src;
  assign rise = src & ~pulse_d;
endmodule

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: measures clocks between strobe rising edges, locks on EXP_PERIOD, flags errors
module pulse_period_monitor
  import ppm_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 pulse_in,
  output logic [CNT_W-1:0]     period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  state_t state, state_n;
  logic rise;
  logic hit;
  logic [CNT_W-1:0] cnt, cnt_n, period_n;
  logic [3:0] match_cnt, match_n;
  logic pv_n, locked_n, err_n;
  ppm_edge_det u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .rise     (rise)
  );
  assign hit = cnt == CNT_W'(EXP_PERIOD);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    match_n  = match_cnt;
    period_n = period;
    pv_n     = 1'b0;
    locked_n = locked;
    err_n    = 1'b0;
    if (!en) begin
      state_n  = IDLE;
      cnt_n    = '0;
      match_n  = '0;
      locked_n = 1'b0;
    end else if (state == IDLE) begin
      if (rise) begin
        cnt_n   = CNT_W'(1);
        state_n = MEASURE;
      end
    end else if (rise) begin
      period_n = cnt;
      pv_n     = 1'b1;
      cnt_n    = CNT_W'(1);
      if (state == MEASURE) begin
        match_n = hit ? match_cnt + 4'd1 : 4'd0;
        if (match_n == 4'(LOCK_COUNT)) begin
          state_n  = LOCKED;
          locked_n = 1'b1;
        end
      end else if (!hit) begin
        err_n    = 1'b1;
        locked_n = 1'b0;
        match_n  = '0;
        state_n  = MEASURE;
      end
    end else if (cnt == CNT_W'(TIMEOUT)) begin
      err_n    = 1'b1;
      cnt_n    = '0;
      match_n  = '0;
      locked_n = 1'b0;
      state_n  = IDLE;
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= '0;
    end else begin
      cnt          <= cnt_n;
      match_cnt    <= match_n;
      period       <= period_n;
      period_valid <= pv_n;
      locked       <= locked_n;
      err          <= err_n;
      err_cnt      <= err_cnt + ERR_CNT_W'(err_n && err_cnt != '1);
    end
endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: directed vectors against hand-computed periods, lock and error behaviour
module tb_pulse_period_monitor;
  logic clk = 1'b0;
  logic rst_n, en, pulse_in;
  logic [7:0] period;
  logic period_valid, locked, err;
  logic [7:0] err_cnt;
  int vectors = 0;
  int miscompares = 0;
`ifdef PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  pulse_period_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .err_cnt      (err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input string tag, input logic pv, input int per, input logic lk, input logic er);
    cyc(1'b1);
    repeat (LAT) cyc(1'b0);
    chk({tag, ".pv"}, period_valid, pv);
    if (pv) chk({tag, ".period"}, period, per);
    chk({tag, ".locked"}, locked, lk);
    chk({tag, ".err"}, err, er);
  endtask
  task automatic gap(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      cyc(1'b0);
      if (i == 0) chk({tag, ".pv_off"}, period_valid, 1'b0);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.period", period, 0);
    chk("rst.pv", period_valid, 0);
    chk("rst.locked", locked, 0);
    chk("rst.err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    en = 1'b1;
    cyc(1'b0);
    pulse("first", 1'b0, 0, 1'b0, 1'b0);
    gap("first", 3 - LAT);
    pulse("p1", 1'b1, 4, 1'b0, 1'b0);
    gap("p1", 3 - LAT);
    pulse("p2", 1'b1, 4, 1'b0, 1'b0);
    gap("p2", 3 - LAT);
    pulse("lock", 1'b1, 4, 1'b1, 1'b0);
    gap("lock", 5 - LAT);
    pulse("mis6", 1'b1, 6, 1'b0, 1'b1);
    chk("mis6.err_cnt", err_cnt, 1);
    gap("mis6", 3 - LAT);
    pulse("r1", 1'b1, 4, 1'b0, 1'b0);
    gap("r1", 3 - LAT);
    pulse("r2", 1'b1, 4, 1'b0, 1'b0);
    gap("r2", 3 - LAT);
    pulse("relock", 1'b1, 4, 1'b1, 1'b0);
    for (int j = 1; j <= 20; j++) begin
      cyc(1'b0);
      if (j == 15 || j == 16 || j == 17) chk($sformatf("to.err%0d", j), err, j == 16);
    end
    chk("to.locked", locked, 0);
    chk("to.err_cnt", err_cnt, 2);
    pulse("to.idle", 1'b0, 0, 1'b0, 1'b0);
    gap("p16", 15 - LAT);
    pulse("p16", 1'b1, 16, 1'b0, 1'b0);
    gap("p16b", 3 - LAT);
    pulse("q1", 1'b1, 4, 1'b0, 1'b0);
    gap("q1", 3 - LAT);
    pulse("q2", 1'b1, 4, 1'b0, 1'b0);
    gap("q2", 3 - LAT);
    pulse("q3", 1'b1, 4, 1'b1, 1'b0);
    chk("q3.err_cnt", err_cnt, 2);
    en = 1'b0;
    cyc(1'b0);
    chk("en0.locked", locked, 0);
    chk("en0.period", period, 4);
    chk("en0.err_cnt", err_cnt, 2);
    en = 1'b1;
    cyc(1'b0);
    pulse("e.first", 1'b0, 0, 1'b0, 1'b0);
    gap("e0", 3 - LAT);
    pulse("e1", 1'b1, 4, 1'b0, 1'b0);
    gap("e1", 3 - LAT);
    pulse("e2", 1'b1, 4, 1'b0, 1'b0);
    gap("e2", 3 - LAT);
    pulse("e3", 1'b1, 4, 1'b1, 1'b0);
    gap("e3", 1);
    rst_n = 1'b0;
    #2;
    chk("arst.locked", locked, 0);
    chk("arst.period", period, 0);
    chk("arst.err_cnt", err_cnt, 0);
    chk("arst.pv", period_valid, 0);
    chk("arst.err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
